// File: rtl/jnwtr_bist_pkg.sv
// Shared types, constants and the LFSR step function for the JNWTR cell-array BIST.
package jnwtr_bist_pkg;

    localparam int                LFSR_W       = 16;
    localparam logic [LFSR_W-1:0] TAP_MASK     = 16'hB400;  // taps b15, b13, b12, b10
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef enum logic {
        MODE_GEN,
        MODE_MISR
    } lfsr_mode_t;

    // One Fibonacci step: shift left, feedback into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & TAP_MASK)};
    endfunction

endpackage

// File: rtl/jnwtr_bist_lfsr16.sv
// 16-bit shift register used both as the pattern generator and as the MISR.
// In MISR mode the parallel input is XORed into every step.
module jnwtr_bist_lfsr16
    import jnwtr_bist_pkg::*;
(
    input  logic              i_ck,
    input  logic              i_rst,
    input  logic [LFSR_W-1:0] i_rst_val,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_load_val,
    input  logic              i_step,
    input  lfsr_mode_t        i_mode,
    input  logic [LFSR_W-1:0] i_par,
    output logic [LFSR_W-1:0] o_q
);

    logic [LFSR_W-1:0] r_q;
    logic [LFSR_W-1:0] w_par;

    assign w_par = (i_mode == MODE_MISR) ? i_par : '0;

    // State register: reset value, run-start load, or one step.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_ck) begin
        if (i_rst) begin
            r_q <= i_rst_val;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_step) begin
            r_q <= lfsr_next(r_q) ^ w_par;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jnwtr_cell_bist.sv
// BIST sequencer for the JNWTR cell-library test array: drives LFSR stimulus,
// captures the array response one cycle later and compacts it into a MISR.
// Optional serial signature readout is built when JNWTR_BIST_SERIAL_EN is defined.
module jnwtr_cell_bist
    import jnwtr_bist_pkg::*;
#(
    parameter int                N_IN   = 24,
    parameter int                N_OUT  = 24,
    parameter int                CYCLES = 1024,
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              START,
    input  logic [N_OUT-1:0]  RESP,
    input  logic              SHIFT,
    output logic [N_IN-1:0]   STIM,
    output logic              BUSY,
    output logic              DONE,
    output logic [LFSR_W-1:0] SIG,
    output logic              SDO
);

    // An all-zero seed would lock the generator, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;
    localparam logic [15:0]       LAST_CNT = 16'(CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_start_run;
    logic [15:0]        r_cnt;
    logic               r_drain_ph;
    logic [N_OUT-1:0]   r_cap;
    logic               r_cap_vld;   // r_cap holds a response to a real pattern
    logic [N_IN-1:0]    r_stim;
    logic [N_IN-1:0]    w_stim_map;
    logic [LFSR_W-1:0]  w_fold;
    logic [LFSR_W-1:0]  w_lfsr;
    logic [LFSR_W-1:0]  w_sig;

    // Next-state decode. The DONE port shadows the DONE literal, hence the scoped name.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_start_run = 1'b0;
        case (r_state)
            IDLE, jnwtr_bist_pkg::DONE: begin
                if (START) begin
                    w_state_nxt = RUN;
                    w_start_run = 1'b1;
                end
            end
            RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain_ph) begin
                    w_state_nxt = jnwtr_bist_pkg::DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stimulus map: low lines copy the LFSR, upper lines XOR two LFSR bits.
    always_comb begin
        w_stim_map = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (i < LFSR_W) begin
                w_stim_map[i] = w_lfsr[i % LFSR_W];
            end else begin
                w_stim_map[i] = w_lfsr[i % LFSR_W] ^ w_lfsr[(i + 7) % LFSR_W];
            end
        end
    end

    // Fold the captured response down to MISR width.
    always_comb begin
        w_fold = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_fold[k % LFSR_W] = w_fold[k % LFSR_W] ^ r_cap[k];
        end
    end

    // Pattern counter, drain phase, stimulus and capture registers.
    // The capture taken on the first RUN edge sees the previous stimulus, so it is never folded.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_cnt      <= '0;
            r_drain_ph <= 1'b0;
            r_cap      <= '0;
            r_cap_vld  <= 1'b0;
            r_stim     <= '0;
        end else begin
            r_cap_vld <= 1'b0;
            if (w_start_run) begin
                r_cnt      <= '0;
                r_drain_ph <= 1'b0;
            end else if (r_state == RUN) begin
                r_stim    <= w_stim_map;
                r_cnt     <= r_cnt + 16'd1;
                r_cap     <= RESP;
                r_cap_vld <= (r_cnt != 16'd0);
            end else if (r_state == DRAIN) begin
                r_drain_ph <= ~r_drain_ph;
                if (!r_drain_ph) begin
                    r_cap     <= RESP;
                    r_cap_vld <= 1'b1;
                end
            end
        end
    end

    jnwtr_bist_lfsr16 u_gen (
        .i_ck       (CK),
        .i_rst      (RST),
        .i_rst_val  (SEED_EFF),
        .i_load     (w_start_run),
        .i_load_val (SEED_EFF),
        .i_step     (r_state == RUN),
        .i_mode     (MODE_GEN),
        .i_par      ('0),
        .o_q        (w_lfsr)
    );

    jnwtr_bist_lfsr16 u_misr (
        .i_ck       (CK),
        .i_rst      (RST),
        .i_rst_val  ('0),
        .i_load     (w_start_run),
        .i_load_val ('0),
        .i_step     (r_cap_vld),
        .i_mode     (MODE_MISR),
        .i_par      (w_fold),
        .o_q        (w_sig)
    );

    assign STIM = r_stim;
    assign BUSY = (r_state == RUN) || (r_state == DRAIN);
    assign DONE = (r_state == jnwtr_bist_pkg::DONE);
    assign SIG  = w_sig;

`ifdef JNWTR_BIST_SERIAL_EN
    logic [LFSR_W-1:0] r_sh;
    logic              r_sh_ld;
    logic              r_sdo;

    // Serial readout: load the signature on the first DONE cycle, then shift MSB-first.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_sh    <= '0;
            r_sh_ld <= 1'b0;
            r_sdo   <= 1'b0;
        end else if (r_state == jnwtr_bist_pkg::DONE) begin
            if (!r_sh_ld) begin
                r_sh    <= w_sig;
                r_sh_ld <= 1'b1;
            end else if (SHIFT) begin
                r_sdo <= r_sh[LFSR_W-1];
                r_sh  <= {r_sh[LFSR_W-2:0], 1'b0};
            end
        end else begin
            r_sh_ld <= 1'b0;
            r_sdo   <= 1'b0;
        end
    end

    assign SDO = r_sdo;
`else
    logic w_unused_shift;

    assign w_unused_shift = SHIFT;
    assign SDO            = 1'b0;
`endif

endmodule

// File: tb/tb_jnwtr_cell_bist.sv
// Self-checking bench for jnwtr_cell_bist: a 4-pattern instance for timing and
// stimulus checks, a 1024-pattern instance for signature and reset checks.
module tb_jnwtr_cell_bist;

    localparam int          CYC_S   = 4;
    localparam int          CYC_L   = 1024;
    localparam logic [15:0] T_SEED  = 16'hACE1;

    logic        ck = 1'b0;
    always #5 ck = ~ck;

    logic        rst_s, start_s, shift_s, loop_s;
    logic        rst_l, start_l, shift_l, loop_l;
    logic [23:0] resp_s_drv, resp_l_drv;
    logic [23:0] resp_s, resp_l, stim_s, stim_l;
    logic        busy_s, done_s, sdo_s, busy_l, done_l, sdo_l;
    logic [15:0] sig_s, sig_l;

    assign resp_s = loop_s ? stim_s : resp_s_drv;
    assign resp_l = loop_l ? stim_l : resp_l_drv;

    jnwtr_cell_bist #(.N_IN(24), .N_OUT(24), .CYCLES(CYC_S), .SEED(T_SEED)) u_dut_s (
        .CK(ck), .RST(rst_s), .START(start_s), .RESP(resp_s), .SHIFT(shift_s),
        .STIM(stim_s), .BUSY(busy_s), .DONE(done_s), .SIG(sig_s), .SDO(sdo_s)
    );

    jnwtr_cell_bist #(.N_IN(24), .N_OUT(24), .CYCLES(CYC_L), .SEED(T_SEED)) u_dut_l (
        .CK(ck), .RST(rst_l), .START(start_l), .RESP(resp_l), .SHIFT(shift_l),
        .STIM(stim_l), .BUSY(busy_l), .DONE(done_l), .SIG(sig_l), .SDO(sdo_l)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [23:0] stim_q[$];
    logic [15:0] sig_q[$];
    logic [23:0] hist [0:63];
    logic [15:0] last_sig_s;

    // ---------------- reference model ----------------
    function automatic logic [15:0] m_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [23:0] m_map(input logic [15:0] l);
        return {l[7:0] ^ l[14:7], l};
    endfunction

    function automatic logic [15:0] m_fold(input logic [23:0] c);
        return c[15:0] ^ {8'h00, c[23:16]};
    endfunction

    function automatic logic [15:0] m_sig(input int c, input bit loop, input logic [23:0] r);
        logic [15:0] l;
        logic [15:0] s;
        logic [23:0] rsp;
        l = T_SEED;
        s = 16'h0000;
        for (int k = 0; k < c; k++) begin
            rsp = loop ? m_map(l) : r;
            s   = m_next(s) ^ m_fold(rsp);
            l   = m_next(l);
        end
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Pulse START on the short instance and record STIM on every busy cycle (hist[t]).
    task automatic run_s(input int repulse_at, output int blen);
        foreach (hist[i]) hist[i] = 'x;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        blen = 0;
        for (int t = 1; t <= 50; t++) begin
            if (!busy_s) break;
            blen++;
            hist[t] = stim_s;
            if (t == repulse_at) start_s = 1'b1;
            tick();
            start_s = 1'b0;
        end
    endtask

    task automatic run_l(output int blen);
        start_l = 1'b1;
        tick();
        start_l = 1'b0;
        blen = 0;
        for (int t = 1; t <= CYC_L + 100; t++) begin
            if (!busy_l) break;
            blen++;
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_s = 1'b1; rst_l = 1'b1;
        start_s = 1'b0; start_l = 1'b0;
        shift_s = 1'b0; shift_l = 1'b0;
        loop_s = 1'b0; loop_l = 1'b0;
        resp_s_drv = '0; resp_l_drv = '0;
        repeat (3) tick();
        checks++;
        if ({stim_s, busy_s, done_s, sig_s, sdo_s} !== 43'h0) begin
            failures++;
            $display("FAIL reset_short stim=%h busy=%b done=%b sig=%h sdo=%b want all zero",
                     stim_s, busy_s, done_s, sig_s, sdo_s);
        end
        checks++;
        if ({stim_l, busy_l, done_l, sig_l, sdo_l} !== 43'h0) begin
            failures++;
            $display("FAIL reset_long stim=%h busy=%b done=%b sig=%h sdo=%b want all zero",
                     stim_l, busy_l, done_l, sig_l, sdo_l);
        end
        rst_s = 1'b0; rst_l = 1'b0;
        tick();
    endtask

    task automatic test_short_run();
        int          blen;
        logic [15:0] l;
        logic [23:0] exp;
        logic [23:0] last;
        resp_s_drv = 24'($urandom());
        l = T_SEED;
        for (int k = 0; k < CYC_S; k++) begin
            stim_q.push_back(m_map(l));
            l = m_next(l);
        end
        sig_q.push_back(m_sig(CYC_S, 1'b0, resp_s_drv));
        run_s(0, blen);
        checks++;
        if (blen !== CYC_S + 2) begin
            failures++;
            $display("FAIL short_busy_len got=%0d want=%0d", blen, CYC_S + 2);
        end
        checks++;
        if (hist[2][15:0] !== 16'hACE1) begin
            failures++;
            $display("FAIL short_first_stim got=%h want=ace1", hist[2][15:0]);
        end
        checks++;
        if (hist[3][15:0] !== 16'h59C3) begin
            failures++;
            $display("FAIL short_second_stim got=%h want=59c3", hist[3][15:0]);
        end
        last = '0;
        for (int k = 1; k <= CYC_S; k++) begin
            exp  = stim_q.pop_front();
            last = exp;
            checks++;
            if (hist[k + 1] !== exp) begin
                failures++;
                $display("FAIL short_stim_%0d got=%h want=%h", k, hist[k + 1], exp);
            end
        end
        checks++;
        if ({busy_s, done_s} !== 2'b01) begin
            failures++;
            $display("FAIL short_done_flags busy=%b done=%b want busy=0 done=1", busy_s, done_s);
        end
        checks++;
        if (stim_s !== last) begin
            failures++;
            $display("FAIL short_stim_hold got=%h want=%h", stim_s, last);
        end
        exp = {8'h00, sig_q.pop_front()};
        checks++;
        if (sig_s !== exp[15:0]) begin
            failures++;
            $display("FAIL short_sig_const_resp got=%h want=%h", sig_s, exp[15:0]);
        end
    endtask

    task automatic test_start_ignored();
        int blen;
        loop_s = 1'b1;
        sig_q.push_back(m_sig(CYC_S, 1'b1, '0));
        run_s(3, blen);
        checks++;
        if (blen !== CYC_S + 2) begin
            failures++;
            $display("FAIL restart_busy_len got=%0d want=%0d", blen, CYC_S + 2);
        end
        last_sig_s = sig_q.pop_front();
        checks++;
        if (sig_s !== last_sig_s) begin
            failures++;
            $display("FAIL short_sig_loopback got=%h want=%h", sig_s, last_sig_s);
        end
        checks++;
        if (done_s !== 1'b1) begin
            failures++;
            $display("FAIL short_done_after_restart got=%b want=1", done_s);
        end
    endtask

    task automatic test_serial();
`ifdef JNWTR_BIST_SERIAL_EN
        shift_s = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            checks++;
            if (sdo_s !== ((i < 16) ? last_sig_s[15 - i] : 1'b0)) begin
                failures++;
                $display("FAIL serial_bit_%0d got=%b want=%b", i, sdo_s,
                         (i < 16) ? last_sig_s[15 - i] : 1'b0);
            end
        end
        shift_s = 1'b0;
`else
        shift_s = 1'b1;
        repeat (4) tick();
        checks++;
        if (sdo_s !== 1'b0) begin
            failures++;
            $display("FAIL sdo_tied got=%b want=0", sdo_s);
        end
        shift_s = 1'b0;
`endif
    endtask

    task automatic test_zero_resp();
        int blen;
        loop_l = 1'b0;
        resp_l_drv = '0;
        run_l(blen);
        checks++;
        if (blen !== CYC_L + 2) begin
            failures++;
            $display("FAIL long_busy_len got=%0d want=%0d", blen, CYC_L + 2);
        end
        checks++;
        if ({done_l, sig_l} !== {1'b1, 16'h0000}) begin
            failures++;
            $display("FAIL zero_resp_sig done=%b sig=%h want done=1 sig=0000", done_l, sig_l);
        end
    endtask

    task automatic test_back_to_back();
        int          blen;
        logic [15:0] exp;
        loop_l = 1'b1;
        sig_q.push_back(m_sig(CYC_L, 1'b1, '0));
        sig_q.push_back(m_sig(CYC_L, 1'b1, '0));
        for (int r = 0; r < 2; r++) begin
            run_l(blen);
            exp = sig_q.pop_front();
            checks++;
            if ({done_l, sig_l} !== {1'b1, exp}) begin
                failures++;
                $display("FAIL loopback_sig_run%0d done=%b sig=%h want done=1 sig=%h",
                         r, done_l, sig_l, exp);
            end
            checks++;
            if (blen !== CYC_L + 2) begin
                failures++;
                $display("FAIL loopback_busy_len_run%0d got=%0d want=%0d", r, blen, CYC_L + 2);
            end
        end
    endtask

    task automatic test_rst_midrun();
        int rises;
        loop_l = 1'b1;
        start_l = 1'b1;
        tick();
        start_l = 1'b0;
        repeat (9) tick();
        rst_l = 1'b1;
        tick();
        rst_l = 1'b0;
        checks++;
        if ({stim_l, busy_l, done_l, sig_l, sdo_l} !== 43'h0) begin
            failures++;
            $display("FAIL midrun_reset stim=%h busy=%b done=%b sig=%h sdo=%b want all zero",
                     stim_l, busy_l, done_l, sig_l, sdo_l);
        end
        rises = 0;
        for (int t = 0; t < CYC_L + 50; t++) begin
            if (done_l || busy_l) rises++;
            tick();
        end
        checks++;
        if (rises !== 0) begin
            failures++;
            $display("FAIL midrun_no_done active_cycles=%0d want=0", rises);
        end
    endtask

    initial begin
        test_reset();
        test_short_run();
        test_start_ignored();
        test_serial();
        test_zero_resp();
        test_back_to_back();
        test_rst_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
